// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for the 5-stage IF/ID/EX/MEM/WB core.
// - Detects RAW hazards against the instructions in EX and MEM.
// - Runs a small FSM that inserts multi-cycle load-use bubbles.
// - Freezes the pipe on data-memory wait states and flushes on taken branches.
// - Produces registered EX forwarding selects and saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_WIDTH        = 5,
  parameter int LOAD_USE_STALL_CYCLES = 1,
  parameter bit FWD_ENABLE            = 1'b1,
  parameter int PERF_CNT_WIDTH        = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [REG_ADDR_WIDTH-1:0] ID_RS1_ADDR,
  input  logic [REG_ADDR_WIDTH-1:0] ID_RS2_ADDR,
  input  logic                      ID_RS1_USED,
  input  logic                      ID_RS2_USED,
  input  logic [REG_ADDR_WIDTH-1:0] EX_RD_ADDR,
  input  logic                      EX_REG_WRITE,
  input  logic                      EX_MEM_READ,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_RD_ADDR,
  input  logic                      MEM_REG_WRITE,
  input  logic                      MEM_MEM_ACCESS,
  input  logic                      DMEM_READY,
  input  logic                      EX_BRANCH_TAKEN,
  output logic                      PC_STALL,
  output logic                      IF_ID_STALL,
  output logic                      IF_ID_FLUSH,
  output logic                      ID_EX_STALL,
  output logic                      ID_EX_FLUSH,
  output logic                      EX_MEM_STALL,
  output logic                      MEM_WB_FLUSH,
  output logic [1:0]                FWD_A_SEL,
  output logic [1:0]                FWD_B_SEL,
  output logic [PERF_CNT_WIDTH-1:0] STALL_COUNT,
  output logic [PERF_CNT_WIDTH-1:0] FLUSH_COUNT
);

  localparam int CNT_WIDTH = $clog2(LOAD_USE_STALL_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LOAD_USE_STALL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(1);

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EX_MEM  = 2'b01;
  localparam logic [1:0] FWD_MEM_WB  = 2'b10;

  typedef enum logic {RUN, LDSTALL} state_t;

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;

  // A source operand depends on a producer; x0 is hardwired and never does.
  function automatic logic reg_match(input logic                      used,
                                     input logic                      wr,
                                     input logic [REG_ADDR_WIDTH-1:0] rd,
                                     input logic [REG_ADDR_WIDTH-1:0] rs);
    return used && wr && (rd == rs) && (rs != '0);
  endfunction

  logic ex_match_a, ex_match_b, mem_match_a, mem_match_b;
  logic raw_ex, raw_mem, load_use, data_haz, mem_wait, data_stall;
  logic [1:0] fwd_a_next, fwd_b_next;

  assign ex_match_a  = reg_match(ID_RS1_USED, EX_REG_WRITE,  EX_RD_ADDR,  ID_RS1_ADDR);
  assign ex_match_b  = reg_match(ID_RS2_USED, EX_REG_WRITE,  EX_RD_ADDR,  ID_RS2_ADDR);
  assign mem_match_a = reg_match(ID_RS1_USED, MEM_REG_WRITE, MEM_RD_ADDR, ID_RS1_ADDR);
  assign mem_match_b = reg_match(ID_RS2_USED, MEM_REG_WRITE, MEM_RD_ADDR, ID_RS2_ADDR);

  assign raw_ex     = ex_match_a || ex_match_b;
  assign raw_mem    = mem_match_a || mem_match_b;
  assign load_use   = raw_ex && EX_MEM_READ;
  assign data_haz   = FWD_ENABLE ? load_use : (raw_ex || raw_mem);
  assign mem_wait   = MEM_MEM_ACCESS && !DMEM_READY;
  assign data_stall = data_haz || (state == LDSTALL);

  // FSM state register: load-use stall state and remaining bubble count.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // FSM next state: a memory wait freezes everything, a branch cancels the stall.
  // NOTE: defaults first so every path assigns every signal and no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!mem_wait) begin
      case (state)
        RUN: begin
          if (load_use && !EX_BRANCH_TAKEN && (LOAD_USE_STALL_CYCLES > 1)) begin
            state_next = LDSTALL;
            cnt_next   = CNT_LOAD;
          end
        end
        LDSTALL: begin
          if (EX_BRANCH_TAKEN) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - 1'b1;
            if (cnt == CNT_LAST) state_next = RUN;
          end
        end
        default: begin
          state_next = RUN;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // FSM outputs: pipeline controls in priority order, all quiet during reset.
  always_comb begin
    PC_STALL     = 1'b0;
    IF_ID_STALL  = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_STALL  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    EX_MEM_STALL = 1'b0;
    MEM_WB_FLUSH = 1'b0;
    if (RST) begin
      PC_STALL = 1'b0;
    end else if (mem_wait) begin
      PC_STALL     = 1'b1;
      IF_ID_STALL  = 1'b1;
      ID_EX_STALL  = 1'b1;
      EX_MEM_STALL = 1'b1;
      MEM_WB_FLUSH = 1'b1;
    end else if (EX_BRANCH_TAKEN) begin
      // The ID instruction is wrong-path, so any data stall is moot.
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else if (data_stall) begin
      PC_STALL    = 1'b1;
      IF_ID_STALL = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end
  end

  // Forwarding select for the instruction entering EX; the younger producer wins.
  always_comb begin
    fwd_a_next = FWD_REGFILE;
    fwd_b_next = FWD_REGFILE;
    if (FWD_ENABLE && !ID_EX_FLUSH) begin
      if (ex_match_a)       fwd_a_next = FWD_EX_MEM;
      else if (mem_match_a) fwd_a_next = FWD_MEM_WB;
      if (ex_match_b)       fwd_b_next = FWD_EX_MEM;
      else if (mem_match_b) fwd_b_next = FWD_MEM_WB;
    end
  end

  // Forwarding select registers, frozen together with the pipe on a memory wait.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      FWD_A_SEL <= FWD_REGFILE;
      FWD_B_SEL <= FWD_REGFILE;
    end else if (!mem_wait) begin
      FWD_A_SEL <= fwd_a_next;
      FWD_B_SEL <= fwd_b_next;
    end
  end

  // Saturating performance counters for stall and branch-flush cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      STALL_COUNT <= '0;
      FLUSH_COUNT <= '0;
    end else begin
      if (PC_STALL && (STALL_COUNT != '1)) STALL_COUNT <= STALL_COUNT + 1'b1;
      if (IF_ID_FLUSH && (FLUSH_COUNT != '1)) FLUSH_COUNT <= FLUSH_COUNT + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller.
// Two instances share stimulus:
// - u_dut:   LOAD_USE_STALL_CYCLES=2, forwarding on, 4-bit counters.
// - u_nofwd: LOAD_USE_STALL_CYCLES=1, forwarding off, 8-bit counters.
// Each step names the instance it checks.
module tb_pipeline_hazard_controller;

  localparam logic [6:0] C_NONE   = 7'b000_0000;
  localparam logic [6:0] C_DSTALL = 7'b110_0100;  // PC, IF_ID stall, ID_EX flush
  localparam logic [6:0] C_BRANCH = 7'b001_0100;  // IF_ID flush, ID_EX flush
  localparam logic [6:0] C_MWAIT  = 7'b110_1011;  // all stalls, MEM_WB flush

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] ex_rd;
    logic       ex_wr;
    logic       ex_ld;
    logic [4:0] mem_rd;
    logic       mem_wr;
    logic       mem_acc;
    logic       rdy;
    logic       br;
  } stim_t;

  typedef struct {
    string      tag;
    bit         dut;
    logic [6:0] ctrl;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    int         stall_cnt;
    int         flush_cnt;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, ex_rd = '0, mem_rd = '0;
  logic       u1 = 1'b0, u2 = 1'b0, ex_wr = 1'b0, ex_ld = 1'b0;
  logic       mem_wr = 1'b0, mem_acc = 1'b0, rdy = 1'b1, br = 1'b0;

  logic       pc_s0, ifid_s0, ifid_f0, idex_s0, idex_f0, exmem_s0, memwb_f0;
  logic [1:0] fa0, fb0;
  logic [3:0] sc0, fc0;
  logic       pc_s1, ifid_s1, ifid_f1, idex_s1, idex_f1, exmem_s1, memwb_f1;
  logic [1:0] fa1, fb1;
  logic [7:0] sc1, fc1;

  exp_t exp_q[$];
  int   acc_stall [2];
  int   acc_flush [2];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_controller #(
    .REG_ADDR_WIDTH(5), .LOAD_USE_STALL_CYCLES(2), .FWD_ENABLE(1'b1), .PERF_CNT_WIDTH(4)
  ) u_dut (
    .CLK(CLK), .RST(RST),
    .ID_RS1_ADDR(rs1), .ID_RS2_ADDR(rs2), .ID_RS1_USED(u1), .ID_RS2_USED(u2),
    .EX_RD_ADDR(ex_rd), .EX_REG_WRITE(ex_wr), .EX_MEM_READ(ex_ld),
    .MEM_RD_ADDR(mem_rd), .MEM_REG_WRITE(mem_wr), .MEM_MEM_ACCESS(mem_acc),
    .DMEM_READY(rdy), .EX_BRANCH_TAKEN(br),
    .PC_STALL(pc_s0), .IF_ID_STALL(ifid_s0), .IF_ID_FLUSH(ifid_f0),
    .ID_EX_STALL(idex_s0), .ID_EX_FLUSH(idex_f0), .EX_MEM_STALL(exmem_s0),
    .MEM_WB_FLUSH(memwb_f0), .FWD_A_SEL(fa0), .FWD_B_SEL(fb0),
    .STALL_COUNT(sc0), .FLUSH_COUNT(fc0)
  );

  pipeline_hazard_controller #(
    .REG_ADDR_WIDTH(5), .LOAD_USE_STALL_CYCLES(1), .FWD_ENABLE(1'b0), .PERF_CNT_WIDTH(8)
  ) u_nofwd (
    .CLK(CLK), .RST(RST),
    .ID_RS1_ADDR(rs1), .ID_RS2_ADDR(rs2), .ID_RS1_USED(u1), .ID_RS2_USED(u2),
    .EX_RD_ADDR(ex_rd), .EX_REG_WRITE(ex_wr), .EX_MEM_READ(ex_ld),
    .MEM_RD_ADDR(mem_rd), .MEM_REG_WRITE(mem_wr), .MEM_MEM_ACCESS(mem_acc),
    .DMEM_READY(rdy), .EX_BRANCH_TAKEN(br),
    .PC_STALL(pc_s1), .IF_ID_STALL(ifid_s1), .IF_ID_FLUSH(ifid_f1),
    .ID_EX_STALL(idex_s1), .ID_EX_FLUSH(idex_f1), .EX_MEM_STALL(exmem_s1),
    .MEM_WB_FLUSH(memwb_f1), .FWD_A_SEL(fa1), .FWD_B_SEL(fb1),
    .STALL_COUNT(sc1), .FLUSH_COUNT(fc1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic stim_t st(input int a1, input int f1, input int a2, input int f2,
                               input int erd, input int ewr, input int eld,
                               input int mrd, input int mwr, input int macc,
                               input int rd_y, input int b);
    stim_t s;
    s.rst     = 1'b0;
    s.rs1     = 5'(a1);
    s.u1      = f1 != 0;
    s.rs2     = 5'(a2);
    s.u2      = f2 != 0;
    s.ex_rd   = 5'(erd);
    s.ex_wr   = ewr != 0;
    s.ex_ld   = eld != 0;
    s.mem_rd  = 5'(mrd);
    s.mem_wr  = mwr != 0;
    s.mem_acc = macc != 0;
    s.rdy     = rd_y != 0;
    s.br      = b != 0;
    return s;
  endfunction

  // Drive one cycle of stimulus and queue what the checked instance must show.
  // Counter expectations come from the expected controls of earlier steps.
  task automatic step(input string tag, input bit dut, input stim_t s,
                      input logic [6:0] ctrl, input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    int   cmax;
    @(posedge CLK);
    #1;
    RST = s.rst;  rs1 = s.rs1;  u1 = s.u1;  rs2 = s.rs2;  u2 = s.u2;
    ex_rd = s.ex_rd;  ex_wr = s.ex_wr;  ex_ld = s.ex_ld;
    mem_rd = s.mem_rd;  mem_wr = s.mem_wr;  mem_acc = s.mem_acc;
    rdy = s.rdy;  br = s.br;
    if (s.rst) begin
      acc_stall = '{0, 0};
      acc_flush = '{0, 0};
    end
    e.tag = tag;  e.dut = dut;  e.ctrl = ctrl;  e.fwd_a = fa;  e.fwd_b = fb;
    e.stall_cnt = acc_stall[dut];
    e.flush_cnt = acc_flush[dut];
    exp_q.push_back(e);
    cmax = dut ? 255 : 15;
    if (ctrl[6] && acc_stall[dut] < cmax) acc_stall[dut]++;
    if (ctrl[4] && acc_flush[dut] < cmax) acc_flush[dut]++;
  endtask

  // Monitor: compare the checked instance half a cycle after stimulus is applied.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [6:0] ctrl;
      logic [1:0] fa, fb;
      int         sc, fc;
      e = exp_q.pop_front();
      if (e.dut) begin
        ctrl = {pc_s1, ifid_s1, ifid_f1, idex_s1, idex_f1, exmem_s1, memwb_f1};
        fa = fa1;  fb = fb1;  sc = int'(sc1);  fc = int'(fc1);
      end else begin
        ctrl = {pc_s0, ifid_s0, ifid_f0, idex_s0, idex_f0, exmem_s0, memwb_f0};
        fa = fa0;  fb = fb0;  sc = int'(sc0);  fc = int'(fc0);
      end
      check({e.tag, ".ctrl"},  32'(ctrl), 32'(e.ctrl));
      check({e.tag, ".fwd_a"}, 32'(fa),   32'(e.fwd_a));
      check({e.tag, ".fwd_b"}, 32'(fb),   32'(e.fwd_b));
      check({e.tag, ".stall"}, 32'(sc),   32'(e.stall_cnt));
      check({e.tag, ".flush"}, 32'(fc),   32'(e.flush_cnt));
    end
  end

  initial begin
    stim_t s;
    acc_stall = '{0, 0};
    acc_flush = '{0, 0};

    // ---- forwarding instance (L=2) ----
    s = st(5,1, 5,1, 5,1,1, 5,1,0,1,0);  s.rst = 1'b1;
    step("rst",        0, s,                                   C_NONE,   2'b00, 2'b00);
    step("idle",       0, st(0,0, 0,0, 0,0,0, 0,0,0,1,0),      C_NONE,   2'b00, 2'b00);
    step("fwd_ex",     0, st(5,1, 0,0, 5,1,0, 0,0,0,1,0),      C_NONE,   2'b00, 2'b00);
    step("fwd_ex_q",   0, st(0,0, 0,0, 0,0,0, 0,0,0,1,0),      C_NONE,   2'b01, 2'b00);
    step("fwd_mem",    0, st(5,1, 0,0, 0,0,0, 5,1,0,1,0),      C_NONE,   2'b00, 2'b00);
    step("fwd_both",   0, st(5,1, 0,0, 5,1,0, 5,1,0,1,0),      C_NONE,   2'b10, 2'b00);
    step("fwd_b_mem",  0, st(0,0, 6,1, 0,0,0, 6,1,0,1,0),      C_NONE,   2'b01, 2'b00);
    step("x0",         0, st(0,1, 0,1, 0,1,1, 0,1,0,1,0),      C_NONE,   2'b00, 2'b10);
    step("unused",     0, st(9,0, 0,0, 9,1,1, 0,0,0,1,0),      C_NONE,   2'b00, 2'b00);

    // Load-use with two bubbles.
    step("lu0",        0, st(0,0, 7,1, 7,1,1, 0,0,0,1,0),      C_DSTALL, 2'b00, 2'b00);
    step("lu1",        0, st(0,0, 7,1, 0,0,0, 7,1,1,1,0),      C_DSTALL, 2'b00, 2'b00);
    step("lu_done",    0, st(0,0, 7,1, 0,0,0, 0,0,0,1,0),      C_NONE,   2'b00, 2'b00);

    // Branch against a load-use, both in RUN and in LDSTALL.
    step("br_lu",      0, st(8,1, 0,0, 8,1,1, 0,0,0,1,1),      C_BRANCH, 2'b00, 2'b00);
    step("br_after",   0, st(0,0, 0,0, 0,0,0, 0,0,0,1,0),      C_NONE,   2'b00, 2'b00);
    step("lu_b0",      0, st(8,1, 0,0, 8,1,1, 0,0,0,1,0),      C_DSTALL, 2'b00, 2'b00);
    step("lu_b1_br",   0, st(8,1, 0,0, 0,0,0, 8,1,1,1,1),      C_BRANCH, 2'b00, 2'b00);
    step("post_br",    0, st(8,1, 0,0, 0,0,0, 0,0,0,1,0),      C_NONE,   2'b00, 2'b00);

    // Memory wait in RUN holds the forwarding selects.
    step("fwd_set",    0, st(4,1, 0,0, 4,1,0, 0,0,0,1,0),      C_NONE,   2'b00, 2'b00);
    step("mw_run",     0, st(0,0, 0,0, 0,0,0, 0,0,1,0,0),      C_MWAIT,  2'b01, 2'b00);
    step("mw_hold",    0, st(0,0, 0,0, 0,0,0, 0,0,0,1,0),      C_NONE,   2'b01, 2'b00);

    // Memory wait inside LDSTALL freezes the bubble counter.
    step("mw_lu0",     0, st(0,0, 7,1, 7,1,1, 0,0,0,1,0),      C_DSTALL, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++)
      step("mw_wait",  0, st(0,0, 7,1, 0,0,0, 7,1,1,0,0),      C_MWAIT,  2'b00, 2'b00);
    step("mw_resume",  0, st(0,0, 7,1, 0,0,0, 7,1,1,1,0),      C_DSTALL, 2'b00, 2'b00);
    step("mw_done",    0, st(0,0, 7,1, 0,0,0, 0,0,0,1,0),      C_NONE,   2'b00, 2'b00);
    step("mw_br",      0, st(0,0, 0,0, 0,0,0, 0,0,1,0,1),      C_MWAIT,  2'b00, 2'b00);
    step("br_apply",   0, st(0,0, 0,0, 0,0,0, 0,0,0,1,1),      C_BRANCH, 2'b00, 2'b00);

    // Asynchronous reset in the middle of LDSTALL.
    step("rst_lu0",    0, st(0,0, 7,1, 7,1,1, 0,0,0,1,0),      C_DSTALL, 2'b00, 2'b00);
    s = st(0,0, 7,1, 0,0,0, 7,1,1,1,0);  s.rst = 1'b1;
    step("rst_mid",    0, s,                                   C_NONE,   2'b00, 2'b00);
    step("rst_rel",    0, st(0,0, 7,1, 0,0,0, 0,0,0,1,0),      C_NONE,   2'b00, 2'b00);

    // Twenty stall cycles saturate the 4-bit stall counter at 15.
    for (int i = 0; i < 20; i++)
      step("sat",      0, st(0,0, 7,1, 7,1,1, 0,0,0,1,0),      C_DSTALL, 2'b00, 2'b00);
    step("sat_end",    0, st(0,0, 0,0, 0,0,0, 0,0,0,1,0),      C_NONE,   2'b00, 2'b00);

    // ---- no-forwarding instance (L=1) ----
    s = st(0,0, 0,0, 0,0,0, 0,0,0,1,0);  s.rst = 1'b1;
    step("nf_rst",     1, s,                                   C_NONE,   2'b00, 2'b00);
    step("nf_ex_raw",  1, st(3,1, 0,0, 3,1,0, 0,0,0,1,0),      C_DSTALL, 2'b00, 2'b00);
    step("nf_mem_raw", 1, st(3,1, 0,0, 0,0,0, 3,1,0,1,0),      C_DSTALL, 2'b00, 2'b00);
    step("nf_clear",   1, st(3,1, 0,0, 0,0,0, 0,0,0,1,0),      C_NONE,   2'b00, 2'b00);
    step("nf_lu",      1, st(0,0, 3,1, 3,1,1, 0,0,0,1,0),      C_DSTALL, 2'b00, 2'b00);
    step("nf_lu_mem",  1, st(0,0, 3,1, 0,0,0, 3,1,1,1,0),      C_DSTALL, 2'b00, 2'b00);
    step("nf_done",    1, st(0,0, 3,1, 0,0,0, 0,0,0,1,0),      C_NONE,   2'b00, 2'b00);
    step("nf_x0",      1, st(0,1, 0,0, 0,1,0, 0,0,0,1,0),      C_NONE,   2'b00, 2'b00);

    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
